handshake_rr_arbiter: RTL

HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

---
 rtl/handshake_rr_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/handshake_rr_arbiter.sv
// N-way round-robin arbiter feeding a single registered valid/ready output
// stage, with a free-running count of completed output handshakes.
module handshake_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_src,
  input  logic               out_ready,
  output logic [15:0]        xfer_cnt
);

  logic [SW-1:0]    ptr;
  logic             load;
  logic [N-1:0]     valid_rot;
  logic             win_found;
  logic [SW-1:0]    win_off;
  logic [SW:0]      win_sum;
  logic [SW-1:0]    win_idx;
  logic [SW-1:0]    ptr_next;
  logic             accept;
  logic [WIDTH-1:0] data_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  assign load = ~out_valid | out_ready;

  // Rotate the valid vector so bit 0 is the requester at ptr; the lowest set
  // bit of the rotated vector is the winner's offset in the search order.
  assign valid_rot = N'({req_valid, req_valid} >> ptr);

  always_comb begin
    win_found = 1'b0;
    win_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        win_found = 1'b1;
        win_off   = SW'(k);
      end
    end
  end

  // Map the offset back to an absolute index modulo N (N need not be a power of two).
  assign win_sum  = {1'b0, ptr} + {1'b0, win_off};
  assign win_idx  = (win_sum >= (SW+1)'(N)) ? SW'(win_sum - (SW+1)'(N)) : win_sum[SW-1:0];
  assign ptr_next = (win_idx == SW'(N - 1)) ? '0 : win_idx + SW'(1);

  assign accept    = load & win_found & ~rst;
  assign req_ready = accept ? (N'(1) << win_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (win_found) begin
        out_valid <= 1'b1;
        out_data  <= data_arr[win_idx];
        out_src   <= win_idx;
        ptr       <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

endmodule
